// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for the shared memory bus with tag-ownership tracking
package mem_arbiter_pkg;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } BUS_COMMAND;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  BUS_COMMAND       Icache2mem_command,
  input  logic [XLEN-1:0]  Icache2mem_addr,
  input  BUS_COMMAND       Dcache2mem_command,
  input  logic [XLEN-1:0]  Dcache2mem_addr,
  input  logic [63:0]      Dcache2mem_data,
  input  logic [3:0]       mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [3:0]       mem2proc_tag,
  output BUS_COMMAND       proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [3:0]       mem2Icache_response,
  output logic [3:0]       mem2Dcache_response,
  output logic             mem2Icache_response_valid,
  output logic             mem2Dcache_response_valid,
  output logic [63:0]      mem2Icache_data,
  output logic [63:0]      mem2Dcache_data,
  output logic [3:0]       mem2Icache_tag,
  output logic [3:0]       mem2Dcache_tag,
  output logic             arb_error
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0]  starve_cnt;
  logic [15:0] tag_valid;
  logic [15:0] tag_dcache;
  logic        err_q;

  logic [2:0]  starve_eff;
  logic [15:0] valid_eff;
  logic        icache_req, dcache_req, grant_i, grant_d, accepted, ret_hit;
  BUS_COMMAND  granted_cmd;

  // During a reset cycle the outputs already see the cleared state.
  always_comb begin
    icache_req  = (Icache2mem_command != BUS_NONE);
    dcache_req  = (Dcache2mem_command != BUS_NONE);
    starve_eff  = reset ? 3'd0 : starve_cnt;
    valid_eff   = reset ? 16'd0 : tag_valid;
    grant_i     = icache_req && (!dcache_req || (starve_eff >= LIMIT));
    grant_d     = dcache_req && !grant_i;
    accepted    = (grant_i || grant_d) && (mem2proc_response != 4'd0);
    ret_hit     = (mem2proc_tag != 4'd0) && valid_eff[mem2proc_tag];
    granted_cmd = BUS_NONE;
    if (grant_i) granted_cmd = Icache2mem_command;
    else if (grant_d) granted_cmd = Dcache2mem_command;
  end

  always_comb begin
    proc2mem_command          = granted_cmd;
    proc2mem_addr             = '0;
    proc2mem_data             = '0;
    mem2Icache_response       = 4'd0;
    mem2Dcache_response       = 4'd0;
    mem2Icache_response_valid = 1'b0;
    mem2Dcache_response_valid = 1'b0;
    mem2Icache_data           = mem2proc_data;
    mem2Dcache_data           = mem2proc_data;
    mem2Icache_tag            = 4'd0;
    mem2Dcache_tag            = 4'd0;
    arb_error                 = err_q && !reset;
    if (grant_i) begin
      proc2mem_addr             = Icache2mem_addr;
      mem2Icache_response       = mem2proc_response;
      mem2Icache_response_valid = 1'b1;
    end else if (grant_d) begin
      proc2mem_addr             = Dcache2mem_addr;
      proc2mem_data             = Dcache2mem_data;
      mem2Dcache_response       = mem2proc_response;
      mem2Dcache_response_valid = 1'b1;
    end
    if (ret_hit) begin
      if (tag_dcache[mem2proc_tag]) mem2Dcache_tag = mem2proc_tag;
      else                          mem2Icache_tag = mem2proc_tag;
    end
  end

  // A return and a re-allocation of the same tag in one cycle is legal: the allocation write lands last.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt <= 3'd0;
      tag_valid  <= '0;
      tag_dcache <= '0;
      err_q      <= 1'b0;
    end else begin
      if (!icache_req || (grant_i && (mem2proc_response != 4'd0)))
        starve_cnt <= 3'd0;
      else if (starve_cnt != 3'd7)
        starve_cnt <= starve_cnt + 3'd1;

      if (mem2proc_tag != 4'd0) begin
        if (tag_valid[mem2proc_tag]) tag_valid[mem2proc_tag] <= 1'b0;
        else                         err_q <= 1'b1;
      end

      if (accepted && (granted_cmd == BUS_LOAD)) begin
        if (tag_valid[mem2proc_response] && (mem2proc_response != mem2proc_tag))
          err_q <= 1'b1;
        tag_valid[mem2proc_response]  <= 1'b1;
        tag_dcache[mem2proc_response] <= grant_d;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench for mem_arbiter against a behavioural model
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int LIM = 4;

  logic             clock = 1'b0;
  logic             reset;
  BUS_COMMAND       Icache2mem_command, Dcache2mem_command;
  logic [XLEN-1:0]  Icache2mem_addr, Dcache2mem_addr;
  logic [63:0]      Dcache2mem_data, mem2proc_data;
  logic [3:0]       mem2proc_response, mem2proc_tag;
  BUS_COMMAND       proc2mem_command;
  logic [XLEN-1:0]  proc2mem_addr;
  logic [63:0]      proc2mem_data, mem2Icache_data, mem2Dcache_data;
  logic [3:0]       mem2Icache_response, mem2Dcache_response, mem2Icache_tag, mem2Dcache_tag;
  logic             mem2Icache_response_valid, mem2Dcache_response_valid, arb_error;

  int checks = 0;
  int errors = 0;

  int starve_m;
  bit valid_m[16];
  bit own_d_m[16];
  bit err_m;

  mem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .Icache2mem_command(Icache2mem_command), .Icache2mem_addr(Icache2mem_addr),
    .Dcache2mem_command(Dcache2mem_command), .Dcache2mem_addr(Dcache2mem_addr),
    .Dcache2mem_data(Dcache2mem_data),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data),
    .mem2Icache_response(mem2Icache_response), .mem2Dcache_response(mem2Dcache_response),
    .mem2Icache_response_valid(mem2Icache_response_valid),
    .mem2Dcache_response_valid(mem2Dcache_response_valid),
    .mem2Icache_data(mem2Icache_data), .mem2Dcache_data(mem2Dcache_data),
    .mem2Icache_tag(mem2Icache_tag), .mem2Dcache_tag(mem2Dcache_tag),
    .arb_error(arb_error)
  );

  always #5 clock = ~clock;

  // 0: nobody, 1: icache, 2: dcache
  function automatic int who_wins();
    int s;
    s = reset ? 0 : starve_m;
    if (Icache2mem_command == BUS_NONE && Dcache2mem_command == BUS_NONE) return 0;
    if (Dcache2mem_command == BUS_NONE) return 1;
    if (Icache2mem_command == BUS_NONE) return 2;
    return (s >= LIM) ? 1 : 2;
  endfunction

  task automatic idle();
    reset = 1'b0;
    Icache2mem_command = BUS_NONE; Icache2mem_addr = '0;
    Dcache2mem_command = BUS_NONE; Dcache2mem_addr = '0; Dcache2mem_data = '0;
    mem2proc_response = 4'd0; mem2proc_data = '0; mem2proc_tag = 4'd0;
  endtask

  // Moves the model across one rising edge using the inputs held this cycle.
  task automatic advance();
    int w;
    BUS_COMMAND c;
    w = who_wins();
    @(posedge clock);
    if (reset) begin
      starve_m = 0; err_m = 0;
      for (int i = 0; i < 16; i++) valid_m[i] = 0;
    end else begin
      if (Icache2mem_command == BUS_NONE || (w == 1 && mem2proc_response != 0)) starve_m = 0;
      else if (starve_m < 7) starve_m++;
      if (mem2proc_tag != 0) begin
        if (valid_m[mem2proc_tag]) valid_m[mem2proc_tag] = 0;
        else err_m = 1;
      end
      if (mem2proc_response != 0 && w != 0) begin
        c = (w == 1) ? Icache2mem_command : Dcache2mem_command;
        if (c == BUS_LOAD) begin
          if (valid_m[mem2proc_response]) err_m = 1;
          valid_m[mem2proc_response] = 1;
          own_d_m[mem2proc_response] = (w == 2);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    advance();
    advance();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #1;
    checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL reset_err_comb: got %0b expected 0", arb_error); end
    advance();
    checks++; if (proc2mem_command !== BUS_NONE) begin errors++; $display("FAIL reset_cmd: got %0d expected 0", proc2mem_command); end
    checks++; if (proc2mem_addr !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", proc2mem_addr); end
    checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", arb_error); end
    reset = 1'b0;
    advance();
  endtask

  task automatic test_dcache_load();
    do_reset();
    Dcache2mem_command = BUS_LOAD; Dcache2mem_addr = 32'h100; mem2proc_response = 4'd3;
    #1;
    checks++; if (proc2mem_addr !== 32'h100) begin errors++; $display("FAIL dl_addr: got %h expected 100", proc2mem_addr); end
    checks++; if (mem2Dcache_response !== 4'd3 || mem2Dcache_response_valid !== 1'b1) begin
      errors++; $display("FAIL dl_resp: got %0d/%0b expected 3/1", mem2Dcache_response, mem2Dcache_response_valid); end
    checks++; if (mem2Icache_response !== 4'd0 || mem2Icache_response_valid !== 1'b0) begin
      errors++; $display("FAIL dl_iresp: got %0d/%0b expected 0/0", mem2Icache_response, mem2Icache_response_valid); end
    advance();
    idle();
    mem2proc_tag = 4'd3; mem2proc_data = 64'h0123_4567_89AB_CDEF;
    #1;
    checks++; if (mem2Dcache_tag !== 4'd3 || mem2Icache_tag !== 4'd0) begin
      errors++; $display("FAIL dl_tag: got d=%0d i=%0d expected d=3 i=0", mem2Dcache_tag, mem2Icache_tag); end
    checks++; if (mem2Icache_data !== 64'h0123_4567_89AB_CDEF || mem2Dcache_data !== 64'h0123_4567_89AB_CDEF) begin
      errors++; $display("FAIL dl_data: got %h/%h expected 0123456789abcdef", mem2Icache_data, mem2Dcache_data); end
    advance();
    idle();
    mem2proc_tag = 4'd3;
    #1;
    checks++; if (mem2Dcache_tag !== 4'd0) begin errors++; $display("FAIL dl_cleared: got %0d expected 0", mem2Dcache_tag); end
    advance();
    checks++; if (arb_error !== 1'b1) begin errors++; $display("FAIL dl_reret_err: got %0b expected 1", arb_error); end
  endtask

  task automatic test_starve();
    do_reset();
    Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h40;
    Dcache2mem_command = BUS_STORE; Dcache2mem_addr = 32'h80;
    for (int k = 0; k < 10; k++) begin
      mem2proc_response = 4'(k + 1);
      #1;
      checks++;
      if (mem2Icache_response_valid !== ((k % (LIM + 1)) == LIM)) begin
        errors++; $display("FAIL starve_grant[%0d]: got icache=%0b expected %0b", k, mem2Icache_response_valid, (k % (LIM + 1)) == LIM);
      end
      advance();
    end
    checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL starve_err: got %0b expected 0", arb_error); end
  endtask

  task automatic test_store();
    do_reset();
    Dcache2mem_command = BUS_STORE; Dcache2mem_addr = 32'h200; Dcache2mem_data = 64'hDEAD_BEEF; mem2proc_response = 4'd5;
    #1;
    checks++; if (proc2mem_command !== BUS_STORE || proc2mem_data !== 64'hDEAD_BEEF) begin
      errors++; $display("FAIL st_fwd: got %0d/%h expected 2/deadbeef", proc2mem_command, proc2mem_data); end
    advance();
    idle();
    mem2proc_tag = 4'd5;
    #1;
    checks++; if (mem2Icache_tag !== 4'd0 || mem2Dcache_tag !== 4'd0) begin
      errors++; $display("FAIL st_tag: got i=%0d d=%0d expected 0/0", mem2Icache_tag, mem2Dcache_tag); end
    advance();
    checks++; if (arb_error !== 1'b1) begin errors++; $display("FAIL st_err: got %0b expected 1", arb_error); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h8; mem2proc_response = 4'd2;
    advance();
    idle();
    Dcache2mem_command = BUS_LOAD; Dcache2mem_addr = 32'h18; mem2proc_response = 4'd2; mem2proc_tag = 4'd2;
    #1;
    checks++; if (mem2Icache_tag !== 4'd2 || mem2Dcache_tag !== 4'd0) begin
      errors++; $display("FAIL sc_route: got i=%0d d=%0d expected 2/0", mem2Icache_tag, mem2Dcache_tag); end
    advance();
    idle();
    mem2proc_tag = 4'd2;
    #1;
    checks++; if (mem2Dcache_tag !== 4'd2 || mem2Icache_tag !== 4'd0) begin
      errors++; $display("FAIL sc_owner: got i=%0d d=%0d expected 0/2", mem2Icache_tag, mem2Dcache_tag); end
    checks++; if (arb_error !== 1'b0) begin errors++; $display("FAIL sc_err: got %0b expected 0", arb_error); end
    advance();
  endtask

  task automatic test_saturate();
    do_reset();
    Icache2mem_command = BUS_LOAD; Icache2mem_addr = 32'h30; mem2proc_response = 4'd0;
    for (int k = 0; k < 9; k++) advance();
    checks++; if (dut.starve_cnt !== 3'd7) begin errors++; $display("FAIL sat_cnt: got %0d expected 7", dut.starve_cnt); end
    mem2proc_response = 4'd4;
    advance();
    checks++; if (dut.starve_cnt !== 3'd0) begin errors++; $display("FAIL sat_clear: got %0d expected 0", dut.starve_cnt); end
    idle();
    advance();
  endtask

  task automatic test_reset_mid();
    do_reset();
    Icache2mem_command = BUS_LOAD; mem2proc_response = 4'd1;
    advance();
    idle();
    Dcache2mem_command = BUS_LOAD; mem2proc_response = 4'd4;
    advance();
    do_reset();
    mem2proc_tag = 4'd1;
    #1;
    checks++; if (mem2Icache_tag !== 4'd0 || mem2Dcache_tag !== 4'd0) begin
      errors++; $display("FAIL rm_tag: got i=%0d d=%0d expected 0/0", mem2Icache_tag, mem2Dcache_tag); end
    advance();
    checks++; if (arb_error !== 1'b1) begin errors++; $display("FAIL rm_err: got %0b expected 1", arb_error); end
  endtask

  task automatic test_random();
    int w;
    BUS_COMMAND e_cmd;
    logic [XLEN-1:0] e_addr;
    logic [63:0] e_data;
    logic [3:0] e_itag, e_dtag;
    bit hit;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      Icache2mem_command = ($urandom_range(0, 1) == 1) ? BUS_LOAD : BUS_NONE;
      Icache2mem_addr = $urandom & 32'hFFFF_FFF8;
      Dcache2mem_command = BUS_COMMAND'($urandom_range(0, 2));
      Dcache2mem_addr = $urandom;
      Dcache2mem_data = {$urandom, $urandom};
      mem2proc_response = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_tag = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      mem2proc_data = {$urandom, $urandom};
      #1;
      w = who_wins();
      e_cmd = (w == 1) ? Icache2mem_command : (w == 2) ? Dcache2mem_command : BUS_NONE;
      e_addr = (w == 1) ? Icache2mem_addr : (w == 2) ? Dcache2mem_addr : '0;
      e_data = (w == 2) ? Dcache2mem_data : '0;
      hit = !reset && mem2proc_tag != 0 && valid_m[mem2proc_tag];
      e_itag = (hit && !own_d_m[mem2proc_tag]) ? mem2proc_tag : 4'd0;
      e_dtag = (hit && own_d_m[mem2proc_tag]) ? mem2proc_tag : 4'd0;
      checks++;
      if (proc2mem_command !== e_cmd || proc2mem_addr !== e_addr || proc2mem_data !== e_data) begin
        errors++; $display("FAIL rnd_bus[%0d]: got %0d/%h/%h expected %0d/%h/%h", n,
          proc2mem_command, proc2mem_addr, proc2mem_data, e_cmd, e_addr, e_data); end
      checks++;
      if (mem2Icache_response_valid !== (w == 1) || mem2Dcache_response_valid !== (w == 2) ||
          mem2Icache_response !== ((w == 1) ? mem2proc_response : 4'd0) ||
          mem2Dcache_response !== ((w == 2) ? mem2proc_response : 4'd0)) begin
        errors++; $display("FAIL rnd_resp[%0d]: got i=%0b/%0d d=%0b/%0d expected winner %0d resp %0d", n,
          mem2Icache_response_valid, mem2Icache_response, mem2Dcache_response_valid, mem2Dcache_response, w, mem2proc_response); end
      checks++;
      if (mem2Icache_tag !== e_itag || mem2Dcache_tag !== e_dtag) begin
        errors++; $display("FAIL rnd_tag[%0d]: got i=%0d d=%0d expected i=%0d d=%0d", n, mem2Icache_tag, mem2Dcache_tag, e_itag, e_dtag); end
      checks++;
      if (mem2Icache_data !== mem2proc_data || mem2Dcache_data !== mem2proc_data) begin
        errors++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h", n, mem2Icache_data, mem2Dcache_data, mem2proc_data); end
      checks++;
      if (arb_error !== (err_m && !reset)) begin
        errors++; $display("FAIL rnd_err[%0d]: got %0b expected %0b", n, arb_error, err_m && !reset); end
      advance();
    end
  endtask

  initial begin
    idle();
    @(negedge clock);
    test_reset();
    test_dcache_load();
    test_starve();
    test_store();
    test_same_cycle();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
